// File: rtl/operand_fetch.sv
// Operand fetch stage: drives the register-file read ports and tracks pending writes in a busy scoreboard.
// It stalls on RAW/WAW hazards and registers operands toward execute behind a valid/ready handshake.
module operand_fetch #(
  parameter int TAG_W       = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_rs1_en,
  input  logic                   in_rs2_en,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic                   in_rd_en,
  input  logic [4:0]             in_rd,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   rf_read_flag_1,
  output logic                   rf_read_flag_2,
  output logic [4:0]             rf_reg_read_1,
  output logic [4:0]             rf_reg_read_2,
  input  logic [31:0]            rf_data_1,
  input  logic [31:0]            rf_data_2,
  input  logic                   wb_flag,
  input  logic [4:0]             wb_reg,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic                   out_rd_en,
  output logic [4:0]             out_rd,
  output logic [TAG_W-1:0]       out_tag,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [31:0]            busy_q, busy_d;
  logic [31:0]            wb_hit, eff_busy;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_op1_q, out_op1_d;
  logic [31:0]            out_op2_q, out_op2_d;
  logic                   out_rd_en_q, out_rd_en_d;
  logic [4:0]             out_rd_q, out_rd_d;
  logic [TAG_W-1:0]       out_tag_q, out_tag_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hazard, slot_free, fire;

  // A writeback in the same cycle masks the busy bit: the regfile forwards its data.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_eff_busy
      assign wb_hit[gi]   = wb_flag && (wb_reg == 5'(gi));
      assign eff_busy[gi] = busy_q[gi] & ~wb_hit[gi];
    end
  endgenerate

  assign rf_read_flag_1 = in_valid & in_rs1_en;
  assign rf_read_flag_2 = in_valid & in_rs2_en;
  assign rf_reg_read_1  = in_rs1;
  assign rf_reg_read_2  = in_rs2;

  assign hazard    = (in_rs1_en & eff_busy[in_rs1]) |
                     (in_rs2_en & eff_busy[in_rs2]) |
                     (in_rd_en  & eff_busy[in_rd]);
  assign slot_free = ~out_valid_q | out_ready;
  assign in_ready  = rdy_in & ~rst_in & ~hazard & slot_free;
  assign fire      = in_valid & in_ready;

  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_en_d = out_rd_en_q;
    out_rd_d    = out_rd_q;
    out_tag_d   = out_tag_q;
    stall_cnt_d = stall_cnt_q;
    if (rdy_in) begin
      if (fire) begin
        out_valid_d = 1'b1;
        out_op1_d   = in_rs1_en ? rf_data_1 : 32'd0;
        out_op2_d   = in_rs2_en ? rf_data_2 : 32'd0;
        out_rd_en_d = in_rd_en;
        out_rd_d    = in_rd;
        out_tag_d   = in_tag;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // Clear first so a same-index set in this cycle takes priority.
      if (wb_flag && (wb_reg != 5'd0)) busy_d[wb_reg] = 1'b0;
      if (fire && in_rd_en && (in_rd != 5'd0)) busy_d[in_rd] = 1'b1;
      if (in_valid && hazard && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_en_q <= 1'b0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_en_q <= out_rd_en_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd_en = out_rd_en_q;
  assign out_rd    = out_rd_q;
  assign out_tag   = out_tag_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: expected bundles are queued on accept and
// checked by a monitor on each output transfer; hazards and stalls checked inline.
module tb_operand_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, in_valid, in_ready;
  logic        in_rs1_en, in_rs2_en, in_rd_en;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_tag;
  logic        rf_read_flag_1, rf_read_flag_2;
  logic [4:0]  rf_reg_read_1, rf_reg_read_2;
  logic [31:0] rf_data_1, rf_data_2;
  logic        wb_flag;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, out_rd_en;
  logic [31:0] out_op1, out_op2, out_tag;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic [31:0]  regs [32];
  logic [101:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  // Regfile model with write-through forwarding (x0 never forwarded).
  assign rf_data_1 = (wb_flag && wb_reg != 5'd0 && wb_reg == rf_reg_read_1) ? wb_data : regs[rf_reg_read_1];
  assign rf_data_2 = (wb_flag && wb_reg != 5'd0 && wb_reg == rf_reg_read_2) ? wb_data : regs[rf_reg_read_2];

  operand_fetch #(.TAG_W(32), .STALL_CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd_en(in_rd_en), .in_rd(in_rd), .in_tag(in_tag),
    .rf_read_flag_1(rf_read_flag_1), .rf_read_flag_2(rf_read_flag_2),
    .rf_reg_read_1(rf_reg_read_1), .rf_reg_read_2(rf_reg_read_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_flag(wb_flag), .wb_reg(wb_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd_en(out_rd_en), .out_rd(out_rd),
    .out_tag(out_tag), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] op1, input logic [31:0] op2,
                      input logic rde, input logic [4:0] rd, input logic [31:0] tag);
    exp_q.push_back({op1, op2, rde, rd, tag});
    $display("accept tag=%0h op1=%0h op2=%0h rd_en=%0b rd=%0d", tag, op1, op2, rde, rd);
  endtask

  task automatic set_in(input logic v, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2,
                        input logic rde, input logic [4:0] rd, input logic [31:0] tag);
    in_valid = v; in_rs1_en = r1e; in_rs1 = r1; in_rs2_en = r2e; in_rs2 = r2;
    in_rd_en = rde; in_rd = rd; in_tag = tag;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_flag = 1'b1; wb_reg = r; wb_data = d;
  endtask

  // Advance to the drive point just after the next rising edge; commit writebacks.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (wb_flag && wb_reg != 5'd0) regs[wb_reg] = wb_data;
    wb_flag = 1'b0;
  endtask

  // Monitor: one comparison per completed output transfer.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_bundle", 128'(out_tag), 128'hDEAD);
      end else begin
        logic [101:0] e;
        e = exp_q.pop_front();
        chk("mon_bundle", 128'({out_op1, out_op2, out_rd_en, out_rd, out_tag}), 128'(e));
        $display("transfer tag=%0h op1=%0h op2=%0h rd_en=%0b rd=%0d", out_tag, out_op1, out_op2, out_rd_en, out_rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[0] = 32'h0; regs[3] = 32'h11; regs[5] = 32'h22;
    rst_in = 1'b1; rdy_in = 1'b1; out_ready = 1'b1;
    wb_flag = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    set_in(1, 1, 3, 1, 5, 1, 7, 32'hEEEE);

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("rst_out_bundle", 128'({out_op1, out_op2, out_rd_en, out_rd, out_tag}), 128'd0);
    rst_in = 1'b0;
    in_valid = 1'b0;
    step();

    // Basic fetch: x3=0x11, x5=0x22 -> rd=7
    set_in(1, 1, 3, 1, 5, 1, 7, 32'hA001);
    @(negedge clk_in);
    chk("t1_in_ready", 128'(in_ready), 128'd1);
    chk("t1_read_flags", 128'({rf_read_flag_1, rf_read_flag_2, rf_reg_read_1, rf_reg_read_2}), 128'({2'b11, 5'd3, 5'd5}));
    push(32'h11, 32'h22, 1, 7, 32'hA001);
    step();

    // RAW on x7: stall until writeback of 0x99
    set_in(1, 1, 7, 0, 0, 0, 0, 32'hA002);
    @(negedge clk_in);
    chk("t1_out_valid_next", 128'(out_valid), 128'd1);
    chk("t2_raw_stall0", 128'(in_ready), 128'd0);
    chk("t2_stall_cnt0", 128'(stall_cnt), 128'd0);
    step();
    @(negedge clk_in);
    chk("t2_raw_stall1", 128'(in_ready), 128'd0);
    chk("t2_stall_cnt1", 128'(stall_cnt), 128'd1);
    step();
    @(negedge clk_in);
    chk("t2_raw_stall2", 128'(in_ready), 128'd0);
    chk("t2_stall_cnt2", 128'(stall_cnt), 128'd2);
    step();
    wb(7, 32'h99);
    @(negedge clk_in);
    chk("t2_wb_same_cycle_ready", 128'(in_ready), 128'd1);
    chk("t2_stall_cnt3", 128'(stall_cnt), 128'd3);
    push(32'h99, 32'h0, 0, 0, 32'hA002);
    step();

    // WAW on x4; same-cycle clear+set leaves busy[4] set
    set_in(1, 0, 0, 0, 0, 1, 4, 32'hA003);
    @(negedge clk_in);
    chk("t3_first_rd4_ready", 128'(in_ready), 128'd1);
    push(32'h0, 32'h0, 1, 4, 32'hA003);
    step();
    set_in(1, 0, 0, 0, 0, 1, 4, 32'hA004);
    @(negedge clk_in);
    chk("t3_waw_stall0", 128'(in_ready), 128'd0);
    step();
    @(negedge clk_in);
    chk("t3_waw_stall1", 128'(in_ready), 128'd0);
    chk("t3_stall_cnt4", 128'(stall_cnt), 128'd4);
    step();
    wb(4, 32'h40);
    @(negedge clk_in);
    chk("t3_waw_release", 128'(in_ready), 128'd1);
    chk("t3_stall_cnt5", 128'(stall_cnt), 128'd5);
    push(32'h0, 32'h0, 1, 4, 32'hA004);
    step();
    set_in(1, 1, 4, 0, 0, 0, 0, 32'hA005);
    @(negedge clk_in);
    chk("t3_set_wins_busy4", 128'(in_ready), 128'd0);
    step();
    wb(4, 32'h44);
    @(negedge clk_in);
    chk("t3_fwd_release", 128'(in_ready), 128'd1);
    chk("t3_stall_cnt6", 128'(stall_cnt), 128'd6);
    push(32'h44, 32'h0, 0, 0, 32'hA005);
    step();

    // x0 source/destination never hazards, back-to-back at full rate
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 1, 3, 1, 0, 32'hA006 + k);
      @(negedge clk_in);
      chk("t4_x0_ready", 128'(in_ready), 128'd1);
      push(32'h0, 32'h11, 1, 0, 32'hA006 + k);
      step();
    end
    set_in(1, 1, 0, 1, 0, 0, 0, 32'hA009);
    @(negedge clk_in);
    chk("t4_x0_read_ready", 128'(in_ready), 128'd1);
    chk("t4_stall_cnt6", 128'(stall_cnt), 128'd6);
    push(32'h0, 32'h0, 0, 0, 32'hA009);
    step();
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: bundle holds 3 cycles, next accepted once slot frees
    out_ready = 1'b0;
    set_in(1, 1, 3, 0, 0, 0, 0, 32'hB001);
    @(negedge clk_in);
    chk("t5_first_ready", 128'(in_ready), 128'd1);
    push(32'h11, 32'h0, 0, 0, 32'hB001);
    step();
    set_in(1, 1, 5, 0, 0, 0, 0, 32'hB002);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk("t5_bp_in_ready", 128'(in_ready), 128'd0);
      chk("t5_bp_hold", 128'({out_valid, out_op1, out_tag}), 128'({1'b1, 32'h11, 32'hB001}));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t5_release_ready", 128'(in_ready), 128'd1);
    push(32'h22, 32'h0, 0, 0, 32'hB002);
    step();
    in_valid = 1'b0;
    @(negedge clk_in);
    chk("t5_next_bundle", 128'({out_valid, out_tag}), 128'({1'b1, 32'hB002}));
    step();
    @(negedge clk_in);
    chk("t5_no_duplicate", 128'(out_valid), 128'd0);

    // rdy_in pause and asynchronous reset mid-stall
    step();
    out_ready = 1'b0;
    set_in(1, 0, 0, 0, 0, 1, 9, 32'hC001);
    @(negedge clk_in);
    chk("t6_c_ready", 128'(in_ready), 128'd1);
    push(32'h0, 32'h0, 1, 9, 32'hC001);
    step();
    set_in(1, 1, 9, 0, 0, 0, 0, 32'hD001);
    @(negedge clk_in);
    chk("t6_d_stall", 128'(in_ready), 128'd0);
    chk("t6_stall_cnt6", 128'(stall_cnt), 128'd6);
    step();
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      chk("t6_pause_ready", 128'(in_ready), 128'd0);
      chk("t6_pause_stall_hold", 128'(stall_cnt), 128'd7);
      chk("t6_pause_out_hold", 128'({out_valid, out_tag}), 128'({1'b1, 32'hC001}));
      step();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("t6_resume_stall", 128'(in_ready), 128'd0);
    chk("t6_stall_cnt7", 128'(stall_cnt), 128'd7);
    step();
    #1 rst_in = 1'b1;
    #1;
    chk("t6_async_rst_state", 128'({out_valid, in_ready, stall_cnt, out_tag}), 128'd0);
    exp_q.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    out_ready = 1'b1;
    wb(12, 32'h77);
    @(negedge clk_in);
    chk("t6_busy_cleared_ready", 128'(in_ready), 128'd1);
    push(32'h109, 32'h0, 0, 0, 32'hD001);
    step();
    in_valid = 1'b0;

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) step();
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
    chk("final_stall_cnt", 128'(stall_cnt), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
